// File: rtl/axi_rd_burst_arbiter.sv
// Round-robin read-channel arbiter: one AXI4 read transaction per grant,
// tracked from the AR handshake to the final R beat using the captured ARLEN.
// Also flags RLAST/length mismatches and force-releases a stalled owner.
module axi_rd_burst_arbiter #(
    parameter int N_MST   = 4,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    input  logic [N_MST-1:0] m_arvalid,
    input  logic             s_arready,
    input  logic [LEN_W-1:0] s_arlen,
    input  logic             s_rvalid,
    input  logic             s_rready,
    input  logic             s_rlast,
    output logic [N_MST-1:0] rgrnt,
    output logic             busy,
    output logic             len_err,
    output logic             timeout
);

    localparam int IDX_W = (N_MST > 1) ? $clog2(N_MST) : 1;
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] OWNER_INIT = IDX_W'(N_MST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N_MST-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_owner_q, last_owner_d;
    logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;
    logic               len_err_q, len_err_d;
    logic               timeout_q, timeout_d;

    logic [IDX_W-1:0]   pick_idx;
    logic               pick_vld;
    logic               ar_hs;
    logic               r_beat;
    logic               wd_expired;
    logic               burst_end;
    logic               do_release;

    // Master index offset+1 places after base, wrapped into 0..N_MST-1.
    function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base,
                                                  input int offset);
        int sum;
        sum = int'(base) + 1 + offset;
        if (sum >= N_MST) begin
            sum = sum - N_MST;
        end
        return IDX_W'(sum);
    endfunction

    assign ar_hs      = m_arvalid[owner_q] & s_arready;
    assign r_beat     = s_rvalid & s_rready;
    assign wd_expired = (wdog_q == WD_LAST);
    assign burst_end  = (beat_cnt_q == '0) | s_rlast;

    // Round-robin search: first requester starting just after the last owner.
    always_comb begin
        pick_idx = '0;
        pick_vld = 1'b0;
        for (int i = 0; i < N_MST; i++) begin
            if (!pick_vld && m_arvalid[rr_index(last_owner_q, i)]) begin
                pick_vld = 1'b1;
                pick_idx = rr_index(last_owner_q, i);
            end
        end
    end

    // Next-state logic: grant in IDLE, AR handshake in ADDR, beat counting and watchdog in DATA.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beat_cnt_d   = beat_cnt_q;
        wdog_d       = wdog_q;
        len_err_d    = 1'b0;
        timeout_d    = 1'b0;
        do_release   = 1'b0;

        case (state_q)
            IDLE: begin
                wdog_d = '0;
                if (pick_vld) begin
                    state_d = ADDR;
                    owner_d = pick_idx;
                    grant_d = N_MST'(1) << pick_idx;
                end
            end
            ADDR: begin
                if (ar_hs) begin
                    beat_cnt_d = s_arlen;
                    wdog_d     = '0;
                    state_d    = DATA;
                end else if (wd_expired) begin
                    do_release = 1'b1;
                    timeout_d  = 1'b1;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            DATA: begin
                if (r_beat) begin
                    wdog_d = '0;
                    if (burst_end) begin
                        do_release = 1'b1;
                        len_err_d  = s_rlast ^ (beat_cnt_q == '0);
                    end else begin
                        beat_cnt_d = beat_cnt_q - LEN_W'(1);
                    end
                end else if (wd_expired) begin
                    do_release = 1'b1;
                    timeout_d  = 1'b1;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        if (do_release) begin
            state_d      = IDLE;
            grant_d      = '0;
            last_owner_d = owner_q;
            beat_cnt_d   = '0;
            wdog_d       = '0;
        end
    end

    // State and output registers; reset drops any grant immediately.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            owner_q      <= '0;
            last_owner_q <= OWNER_INIT;
            beat_cnt_q   <= '0;
            wdog_q       <= '0;
            len_err_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beat_cnt_q   <= beat_cnt_d;
            wdog_q       <= wdog_d;
            len_err_q    <= len_err_d;
            timeout_q    <= timeout_d;
        end
    end

    assign rgrnt   = grant_q;
    assign busy    = (state_q != IDLE);
    assign len_err = len_err_q;
    assign timeout = timeout_q;

endmodule
